ifetch_queue: RTL and testbench

Instruction-fetch queue between the `pc` register and the decode stage. Takes the current word address from `pc`, issues in-order reads to instruction memory over a request/grant port, and pulses `PCEn` so `pc` loads `NextPC` whenever a read is accepted. Returned instructions are buffered with their PCs in a `DEPTH`-entry slot queue and handed to decode over a valid/ready handshake. A redirect (`Flush`) drops queued and in-flight fetches.

---
 rtl/ifetch_pkg.sv | 22 ++
 rtl/ifq_slot_ram.sv | 46 ++++
 rtl/ifetch_queue.sv | 83 ++++++++
 tb/tb_ifetch_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types, constants and helpers for the instruction-fetch queue
package ifetch_pkg;

   localparam int   IFQ_DEPTH_DEFAULT = 4;
   localparam logic RESET_ACTIVE      = 1'b0;

   // One queue slot: fetch address, returned word, and whether the word has arrived
   typedef struct packed {
      logic [31:2] pc;
      logic [31:0] instr;
      logic        filled;
   } ifq_slot_t;

   // Ceiling log2, used for slot index and pointer widths
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/ifq_slot_ram.sv
// rtl/ifq_slot_ram.sv - slot storage: pc write on allocate, instr write on fill, async head read
module ifq_slot_ram
   import ifetch_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT,
   localparam int IW   = clog2(DEPTH)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            alloc_en,
   input  logic [IW-1:0]   alloc_idx,
   input  logic [31:2]     alloc_pc,
   input  logic            fill_en,
   input  logic [IW-1:0]   fill_idx,
   input  logic [31:0]     fill_instr,
   input  logic [IW-1:0]   rd_idx,
   output ifq_slot_t       rd_slot
);

   logic [31:2]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];
   logic [DEPTH-1:0] filled_q;

   // Record the fetch address when a slot is allocated
   always_ff @(posedge Clk) begin
      if (alloc_en) pc_mem[alloc_idx] <= alloc_pc;
   end

   // Record the returned instruction word when a slot is filled
   always_ff @(posedge Clk) begin
      if (fill_en) instr_mem[fill_idx] <= fill_instr;
   end

   // Filled flags: cleared on allocate, set on fill; allocate and fill never hit the same slot
   always_ff @(posedge Clk) begin
      if (Reset == RESET_ACTIVE) begin
         filled_q <= '0;
      end else begin
         if (alloc_en) filled_q[alloc_idx] <= 1'b0;
         if (fill_en)  filled_q[fill_idx]  <= 1'b1;
      end
   end

   assign rd_slot = {pc_mem[rd_idx], instr_mem[rd_idx], filled_q[rd_idx]};

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - in-order instruction fetch queue between pc and decode
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:2] FetchPC,
   output logic        PCEn,
   output logic        MemReq,
   output logic [31:2] MemAddr,
   input  logic        MemGnt,
   input  logic        MemRValid,
   input  logic [31:0] MemRData,
   input  logic        Flush,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] OutInstr,
   output logic [31:2] OutPC
);

   localparam int IW = clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] wptr, fptr, rptr, discard;
   logic [PW-1:0] occupancy, inflight;
   logic          run, grant, fill, drop, pop;
   ifq_slot_t     head;

   assign run       = (Reset != RESET_ACTIVE);
   // Occupancy counts in-flight slots too, so outstanding reads never exceed DEPTH
   assign occupancy = wptr - rptr;
   assign inflight  = wptr - fptr;

   assign MemReq   = run & ~Flush & (occupancy < PW'(DEPTH));
   assign MemAddr  = FetchPC;
   assign grant    = MemReq & MemGnt;
   assign PCEn     = grant;

   // Responses belonging to flushed fetches are swallowed until discard drains
   assign fill     = run & MemRValid & (discard == '0);
   assign drop     = run & MemRValid & (discard != '0);

   assign OutValid = run & (rptr != fptr) & head.filled;
   assign OutInstr = head.instr;
   assign OutPC    = head.pc;
   assign pop      = OutValid & OutReady & ~Flush;

   // Pointer and discard bookkeeping; a flush collapses the queue onto wptr
   always_ff @(posedge Clk) begin
      if (!run) begin
         wptr    <= '0;
         fptr    <= '0;
         rptr    <= '0;
         discard <= '0;
      end else if (Flush) begin
         // Every read still outstanding after this edge must be discarded on return
         discard <= discard + inflight - PW'(MemRValid);
         fptr    <= wptr;
         rptr    <= wptr;
      end else begin
         wptr    <= wptr + PW'(grant);
         fptr    <= fptr + PW'(fill);
         rptr    <= rptr + PW'(pop);
         discard <= discard - PW'(drop);
      end
   end

   ifq_slot_ram #(.DEPTH(DEPTH)) u_slot_ram (
      .Clk        (Clk),
      .Reset      (Reset),
      .alloc_en   (grant),
      .alloc_idx  (wptr[IW-1:0]),
      .alloc_pc   (FetchPC),
      .fill_en    (fill),
      .fill_idx   (fptr[IW-1:0]),
      .fill_instr (MemRData),
      .rd_idx     (rptr[IW-1:0]),
      .rd_slot    (head)
   );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed scoreboard bench for ifetch_queue
module tb_ifetch_queue;

   logic        Clk, Reset;
   logic [31:2] FetchPC;
   logic        PCEn, MemReq, MemGnt, MemRValid, Flush, OutValid, OutReady;
   logic [31:2] MemAddr, OutPC;
   logic [31:0] MemRData, OutInstr;

   ifetch_queue #(.DEPTH(4)) dut (
      .Clk(Clk), .Reset(Reset), .FetchPC(FetchPC), .PCEn(PCEn), .MemReq(MemReq),
      .MemAddr(MemAddr), .MemGnt(MemGnt), .MemRValid(MemRValid), .MemRData(MemRData),
      .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady), .OutInstr(OutInstr),
      .OutPC(OutPC)
   );

   typedef struct { logic [29:0] pc; int due; } pend_t;
   typedef struct { logic [29:0] pc; logic [31:0] instr; } sb_t;

   pend_t pend[$];
   sb_t   sb[$];

   int total = 0, bad = 0;
   int cyc = 0, lat = 1, n_pop = 0;
   logic        o_pcen, o_memreq, o_valid;
   logic [29:0] o_pc, last_pc;
   logic [31:0] o_instr;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [31:0] instr_of(input logic [29:0] a);
      if (a == 30'hC00) return 32'h3C01_1234;
      return {a[27:0], 4'h5} ^ 32'h9E37_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: present memory response, sample outputs, update models, advance to next negedge
   task automatic tick();
      logic rsp;
      sb_t  e;
      rsp = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         MemRValid = 1'b1;
         MemRData  = instr_of(pend[0].pc);
         rsp       = 1'b1;
      end else begin
         MemRValid = 1'b0;
         MemRData  = 32'h0;
      end
      #1;
      o_pcen = PCEn; o_memreq = MemReq; o_valid = OutValid; o_pc = OutPC; o_instr = OutInstr;
      check("memaddr", 32'(MemAddr), 32'(FetchPC));
      if (rsp) void'(pend.pop_front());
      if (o_valid && OutReady && !Flush) begin
         if (sb.size() == 0) begin
            check("unexpected_pop", 32'(o_pc), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("pop_pc", 32'(o_pc), 32'(e.pc));
            check("pop_instr", o_instr, e.instr);
         end
         n_pop++;
         last_pc = o_pc;
      end
      if (o_pcen) begin
         pend.push_back('{pc: FetchPC, due: cyc + lat});
         sb.push_back('{pc: FetchPC, instr: instr_of(FetchPC)});
      end
      if (Flush || !Reset) sb.delete();
      if (!Reset) pend.delete();
      @(posedge Clk);
      @(negedge Clk);
      cyc++;
      if (o_pcen) FetchPC = FetchPC + 30'd1;
   endtask

   task automatic single_fetch(input string tag);
      FetchPC = 30'hC00; MemGnt = 1'b1; OutReady = 1'b1; lat = 1;
      tick();
      check({tag, "_pcen_t"}, 32'(o_pcen), 1);
      MemGnt = 1'b0;
      tick();
      check({tag, "_valid_t1"}, 32'(o_valid), 0);
      tick();
      check({tag, "_valid_t2"}, 32'(o_valid), 1);
      check({tag, "_pc_t2"}, 32'(o_pc), 32'hC00);
      check({tag, "_instr_t2"}, o_instr, 32'h3C01_1234);
   endtask

   initial begin
      int g, p0, it;
      Reset = 1'b0; FetchPC = 30'h0; MemGnt = 1'b1; MemRValid = 1'b0; MemRData = 32'h0;
      Flush = 1'b0; OutReady = 1'b0;
      @(negedge Clk);

      // Reset held for 3 cycles with grant asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_memreq", 32'(o_memreq), 0);
         check("rst_pcen", 32'(o_pcen), 0);
         check("rst_valid", 32'(o_valid), 0);
      end
      Reset = 1'b1;

      single_fetch("single");

      // Back-pressure: exactly 4 grants then stall
      FetchPC = 30'hC00; OutReady = 1'b0; MemGnt = 1'b1; lat = 1; g = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (o_pcen) g++;
      end
      check("bp_grants", g, 4);
      check("bp_memreq_full", 32'(o_memreq), 0);
      MemGnt = 1'b0; OutReady = 1'b1; p0 = n_pop;
      for (int i = 0; i < 4; i++) tick();
      check("bp_pops", n_pop - p0, 4);
      check("bp_last_pc", 32'(last_pc), 32'hC03);
      tick();
      check("bp_resume", 32'(o_memreq), 1);

      // 20 instructions streaming across pointer wrap
      g = 0; p0 = n_pop; it = 0;
      while (n_pop - p0 < 20 && it < 40) begin
         MemGnt = (g < 20);
         tick();
         if (o_pcen) g++;
         it++;
      end
      MemGnt = 1'b0;
      check("run20_pops", n_pop - p0, 20);
      check("run20_throughput", 32'(it <= 22), 1);

      // Flush with two reads in flight on a slow memory
      FetchPC = 30'hC00; OutReady = 1'b1; lat = 3; MemGnt = 1'b1;
      tick();
      tick();
      Flush = 1'b1;
      tick();
      check("flush_memreq", 32'(o_memreq), 0);
      check("flush_pcen", 32'(o_pcen), 0);
      check("flush_valid", 32'(o_valid), 0);
      Flush = 1'b0; FetchPC = 30'hD00; lat = 1; MemGnt = 1'b1; p0 = n_pop;
      tick();
      MemGnt = 1'b0; it = 0;
      while (n_pop == p0 && it < 10) begin tick(); it++; end
      check("flush_new_pops", n_pop - p0, 1);
      check("flush_new_pc", 32'(last_pc), 32'hD00);
      for (int i = 0; i < 3; i++) tick();
      check("flush_no_late", n_pop - p0, 1);

      // Flush together with a response and a ready head
      FetchPC = 30'hE00; OutReady = 1'b0; MemGnt = 1'b1; lat = 1;
      tick();
      lat = 3;
      tick();
      MemGnt = 1'b0;
      tick();
      check("coinc_head_filled", 32'(o_valid), 1);
      tick();
      Flush = 1'b1; OutReady = 1'b1; p0 = n_pop;
      tick();
      check("coinc_rvalid", 32'(MemRValid), 1);
      check("coinc_no_pop", n_pop - p0, 0);
      Flush = 1'b0;
      tick();
      check("coinc_empty", 32'(o_valid), 0);
      FetchPC = 30'hF00; MemGnt = 1'b1; lat = 1; p0 = n_pop;
      tick();
      MemGnt = 1'b0; it = 0;
      while (n_pop == p0 && it < 8) begin tick(); it++; end
      check("coinc_discard_zero", n_pop - p0, 1);
      check("coinc_next_pc", 32'(last_pc), 32'hF00);

      // Reset with three filled entries queued
      FetchPC = 30'hC00; OutReady = 1'b0; MemGnt = 1'b1; lat = 1;
      for (int i = 0; i < 3; i++) tick();
      MemGnt = 1'b0;
      tick();
      check("midrst_pre_valid", 32'(o_valid), 1);
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      tick();
      check("midrst_valid", 32'(o_valid), 0);
      single_fetch("postrst");
      OutReady = 1'b0; MemGnt = 1'b1; g = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (o_pcen) g++;
      end
      check("postrst_capacity", g, 4);
      MemGnt = 1'b0; OutReady = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("final_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
